npu_issue_ctrl: RTL and testbench
=================================

NPU_ISSUE_CTRL -- requirements
Module: npu_issue_ctrl

Interface
REQ-001 SHALL have parameter N_WORDS, default 72: number of result words returned by one compute op.
REQ-002 SHALL have parameter TIMEOUT, default 255: cycles without NPU progress before abort.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port id_matr, input, 1: the ID stage holds a valid matr instruction.
REQ-006 SHALL have port id_matr_op, input, 2: op code; 00 load A, 01 load B, 10 compute, 11 reserved.
REQ-007 SHALL have port npu_ack, input, 1: the NPU accepted the command.
REQ-008 SHALL have port npu_rvalid, input, 1: one NPU result word is valid this cycle.
REQ-009 SHALL have port en_npu, output, 1: command strobe to the NPU.
REQ-010 SHALL have port npu_op, output, 2: latched op code sent with en_npu.
REQ-011 SHALL have port stall, output, 1: freezes the PC and the IF/ID register.
REQ-012 SHALL have port id_ex_bubble, output, 1: forces the ID/EX control field to 0.
REQ-013 SHALL have port rw_en, output, 1: result-word write enable.
REQ-014 SHALL have port rw_idx, output, 7: index of the result word, 0..N_WORDS-1.
REQ-015 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-016 SHALL have port timeout_err, output, 1: sticky abort flag.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, WAIT_RES and DONE.
REQ-018 SHALL move IDLE->ISSUE when id_matr=1 and op!=11, latching op into npu_op; IDLE->DONE when id_matr=1 and op=11, without asserting en_npu.
REQ-019 SHALL drive en_npu=1 throughout ISSUE (level handshake) and SHALL hold npu_op stable until npu_ack is sampled.
REQ-020 SHALL, in ISSUE with npu_ack=1, move to WAIT_RES for op 10 and to DONE for op 00 or 01.
REQ-021 SHALL ignore npu_ack in any state other than ISSUE, and npu_rvalid in any state other than WAIT_RES.
REQ-022 SHALL assert rw_en = (state==WAIT_RES && npu_rvalid), combinationally.
REQ-023 SHALL drive rw_idx from a word counter that is cleared on entry to WAIT_RES and incremented on each rw_en.
REQ-024 SHALL move WAIT_RES->DONE on the cycle rw_en=1 with rw_idx=N_WORDS-1; the counter never wraps.
REQ-025 SHALL drive stall = (IDLE && id_matr) || ISSUE || WAIT_RES, so the matr instruction is held from the first cycle it appears in ID.
REQ-026 SHALL drive id_ex_bubble = stall || DONE, so the held matr instruction never enters EX as a live op.
REQ-027 SHALL, in DONE, assert done=1 and stall=0, then return to IDLE next cycle; a new matr instruction then in ID is issued normally.
REQ-028 SHALL count cycles in ISSUE/WAIT_RES without ack/rvalid with a watchdog that is cleared on progress and on state entry.
REQ-029 SHALL, when the watchdog reaches TIMEOUT, set timeout_err, and move to DONE.
REQ-030 SHALL give ack or rvalid priority over a timeout that occurs in the same cycle.
REQ-031 SHALL produce an end-to-end latency, id_matr to done, of ack cycle + 1 for load ops, and of last rvalid + 1 for compute.

Reset
REQ-032 SHALL, on reset=1 at a clock edge, enter IDLE and clear the word counter, watchdog, npu_op and timeout_err.
REQ-033 SHALL drive every output to 0 during and immediately after reset; reset mid-operation abandons the transfer and does not pulse done.
REQ-034 SHALL clear timeout_err only by reset.

Structure
REQ-035 SHALL place the state encoding, op-code constants and the N_WORDS/TIMEOUT defaults in the shared package npu_ctrl_pkg.
REQ-036 SHALL implement the watchdog as the sub-module npu_wdog (inputs clear and enable; output expired).

Verification
REQ-037 SHALL verify load A: id_matr=1 op=00, ack on the 3rd ISSUE cycle -> en_npu high for 3 cycles, stall high for 4 cycles, done one cycle later, no rw_en.
REQ-038 SHALL verify compute: op=10, ack after 1 cycle, 72 rvalid with gaps -> rw_idx 0..71 in order, done the cycle after idx 71, stall low in DONE.
REQ-039 SHALL verify reserved op: op=11 -> en_npu never high, one stall cycle, then done with id_ex_bubble=1.
REQ-040 SHALL verify timeout: TIMEOUT=8, no ack -> timeout_err=1 after 8 ISSUE cycles, done pulse, timeout_err stays 1 until reset.
REQ-041 SHALL verify mid-op reset: reset asserted at rw_idx=30 -> next cycle IDLE, all outputs 0, no done; a new compute restarts at rw_idx=0.
REQ-042 SHALL verify back-to-back matr: load A then load B in consecutive instructions -> two separate en_npu handshakes, and one bubble per instruction.

Source files
------------

// File: rtl/npu_ctrl_pkg.sv
// npu_ctrl_pkg: shared FSM state encoding, matr op codes and default sizes
// for the NPU issue controller and its watchdog.
package npu_ctrl_pkg;
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RES = 2'd2,
        S_DONE     = 2'd3
    } state_t;
    localparam logic [1:0] OP_LOAD_A  = 2'b00;
    localparam logic [1:0] OP_LOAD_B  = 2'b01;
    localparam logic [1:0] OP_COMPUTE = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;
    localparam int N_WORDS_DEF = 72;
    localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/npu_wdog.sv
// npu_wdog: no-progress watchdog for the NPU issue controller.
// Ports: clk, reset (sync, active-high); clear restarts the count;
// enable counts while high and holds the count at zero while low;
// expired is high on the TIMEOUT-th consecutive enabled cycle without a clear.
module npu_wdog
    import npu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] r_cnt;
    assign expired = enable && (r_cnt == W'(TIMEOUT - 1));
    // The count saturates once expired, so the controller always sees the flag.
    always_ff @(posedge clk) begin
        if (reset || clear || !enable) r_cnt <= '0;
        else if (!expired) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/npu_issue_ctrl.sv
// npu_issue_ctrl: issues matr instructions to the NPU, stalls the front end
// while a command is in flight and steers returning result words.
// Ports: clk, reset (sync, active-high); id_matr/id_matr_op describe the
// instruction held in ID; npu_ack/npu_rvalid come from the NPU;
// en_npu/npu_op form the level command handshake; stall/id_ex_bubble control
// the pipeline; rw_en/rw_idx write result words; done pulses on completion;
// timeout_err is a sticky abort flag cleared only by reset.
module npu_issue_ctrl
    import npu_ctrl_pkg::*;
#(
    parameter int N_WORDS = N_WORDS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_matr,
    input  logic [1:0] id_matr_op,
    input  logic       npu_ack,
    input  logic       npu_rvalid,
    output logic       en_npu,
    output logic [1:0] npu_op,
    output logic       stall,
    output logic       id_ex_bubble,
    output logic       rw_en,
    output logic [6:0] rw_idx,
    output logic       done,
    output logic       timeout_err
);
    localparam logic [6:0] LAST = 7'(N_WORDS - 1);
    state_t     r_state;
    logic [1:0] r_op;
    logic [6:0] r_idx;
    logic       r_err;
    logic       w_ack, w_rv, w_busy, w_expired;
    assign w_ack  = (r_state == S_ISSUE) && npu_ack;
    assign w_rv   = (r_state == S_WAIT_RES) && npu_rvalid;
    assign w_busy = (r_state == S_ISSUE) || (r_state == S_WAIT_RES);
    // Leaving ISSUE/WAIT_RES holds the watchdog at zero, so every entry starts fresh.
    npu_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_ack || w_rv),
        .enable (w_busy),
        .expired(w_expired)
    );
    // Outputs are forced low while reset is held so nothing leaks out mid-reset.
    assign en_npu       = !reset && (r_state == S_ISSUE);
    assign npu_op       = reset ? 2'b00 : r_op;
    assign stall        = !reset && (((r_state == S_IDLE) && id_matr) || w_busy);
    assign id_ex_bubble = stall || (!reset && (r_state == S_DONE));
    assign rw_en        = !reset && w_rv;
    assign rw_idx       = reset ? 7'd0 : r_idx;
    assign done         = !reset && (r_state == S_DONE);
    assign timeout_err  = !reset && r_err;
    // Progress (ack/rvalid) is tested before expiry, so it wins a same-cycle tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_LOAD_A;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (id_matr) begin
                        if (id_matr_op == OP_RSVD) r_state <= S_DONE;
                        else begin
                            r_op    <= id_matr_op;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (npu_ack) begin
                        r_idx   <= '0;
                        r_state <= (r_op == OP_COMPUTE) ? S_WAIT_RES : S_DONE;
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_WAIT_RES: begin
                    if (npu_rvalid) begin
                        if (r_idx == LAST) r_state <= S_DONE;
                        else r_idx <= r_idx + 1'b1;
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_npu_issue_ctrl.sv
// tb_npu_issue_ctrl: randomized self-checking bench for npu_issue_ctrl;
// each transaction's expected cycle-by-cycle outputs come from the issue protocol rules.
module tb_npu_issue_ctrl;
    import npu_ctrl_pkg::*;
    localparam int NW = 72;
    localparam int TO = 8;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_matr = 1'b0;
    logic [1:0] id_matr_op = 2'b00;
    logic       npu_ack = 1'b0;
    logic       npu_rvalid = 1'b0;
    logic       en_npu, stall, id_ex_bubble, rw_en, done, timeout_err;
    logic [1:0] npu_op;
    logic [6:0] rw_idx;
    int         total = 0;
    int         bad = 0;
    logic       m_err = 1'b0;
    always #5 clk = ~clk;
    npu_issue_ctrl #(.N_WORDS(NW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_matr     (id_matr),
        .id_matr_op  (id_matr_op),
        .npu_ack     (npu_ack),
        .npu_rvalid  (npu_rvalid),
        .en_npu      (en_npu),
        .npu_op      (npu_op),
        .stall       (stall),
        .id_ex_bubble(id_ex_bubble),
        .rw_en       (rw_en),
        .rw_idx      (rw_idx),
        .done        (done),
        .timeout_err (timeout_err)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask
    task automatic noise();
        npu_ack    = 1'($urandom);
        npu_rvalid = 1'($urandom);
    endtask
    // Inputs are already applied; sample at the falling edge, then step past the next rising edge.
    task automatic cyc(input string tag, input logic e_en, input logic e_st, input logic e_bub,
                       input logic e_rw, input logic e_done);
        @(negedge clk);
        chk(tag, 32'({en_npu, stall, id_ex_bubble, rw_en, done, timeout_err}),
            32'({e_en, e_st, e_bub, e_rw, e_done, m_err}));
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        id_matr = 1'b0;
        noise();
        @(negedge clk);
        chk("rst_during", 32'({en_npu, stall, id_ex_bubble, rw_en, done, timeout_err, npu_op, rw_idx}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_err = 1'b0;
        noise();
        @(negedge clk);
        chk("rst_after", 32'({en_npu, stall, id_ex_bubble, rw_en, done, timeout_err, npu_op, rw_idx}), 32'd0);
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            id_matr = 1'b0;
            noise();
            cyc("idle", 0, 0, 0, 0, 0);
        end
    endtask
    // Load: ack arrives on ISSUE cycle d; done follows the ack cycle.
    task automatic run_load(input logic [1:0] op, input int d);
        id_matr = 1'b1;
        id_matr_op = op;
        noise();
        cyc("ld_idle", 0, 1, 1, 0, 0);
        for (int i = 1; i <= d; i++) begin
            npu_ack = (i == d);
            npu_rvalid = 1'($urandom);
            chk("ld_op", 32'(npu_op), 32'(op));
            cyc("ld_issue", 1, 1, 1, 0, 0);
        end
        noise();
        cyc("ld_done", 0, 0, 1, 0, 1);
        id_matr = 1'b0;
    endtask
    // Compute: ack on ISSUE cycle d, then NW words with random gaps shorter than TO;
    // abort_at >= 0 resets right after that word index is written.
    task automatic run_compute(input int d, input int abort_at);
        id_matr = 1'b1;
        id_matr_op = OP_COMPUTE;
        noise();
        cyc("cp_idle", 0, 1, 1, 0, 0);
        for (int i = 1; i <= d; i++) begin
            npu_ack = (i == d);
            npu_rvalid = 1'($urandom);
            chk("cp_op", 32'(npu_op), 32'(OP_COMPUTE));
            cyc("cp_issue", 1, 1, 1, 0, 0);
        end
        for (int k = 0; k < NW; k++) begin
            int g;
            g = $urandom_range(0, TO - 1);
            repeat (g) begin
                npu_ack = 1'($urandom);
                npu_rvalid = 1'b0;
                cyc("cp_gap", 0, 1, 1, 0, 0);
            end
            npu_ack = 1'($urandom);
            npu_rvalid = 1'b1;
            chk("cp_idx", 32'(rw_idx), 32'(k));
            cyc("cp_word", 0, 1, 1, 1, 0);
            if (k == abort_at) begin
                do_reset();
                return;
            end
        end
        noise();
        cyc("cp_done", 0, 0, 1, 0, 1);
        id_matr = 1'b0;
    endtask
    task automatic run_rsvd();
        id_matr = 1'b1;
        id_matr_op = OP_RSVD;
        noise();
        cyc("rs_idle", 0, 1, 1, 0, 0);
        noise();
        cyc("rs_done", 0, 0, 1, 0, 1);
        id_matr = 1'b0;
    endtask
    // No ack for TO ISSUE cycles: abort to DONE with the sticky error set.
    task automatic run_timeout(input logic [1:0] op);
        id_matr = 1'b1;
        id_matr_op = op;
        noise();
        cyc("to_idle", 0, 1, 1, 0, 0);
        for (int i = 1; i <= TO; i++) begin
            npu_ack = 1'b0;
            npu_rvalid = 1'($urandom);
            cyc("to_issue", 1, 1, 1, 0, 0);
        end
        m_err = 1'b1;
        noise();
        cyc("to_done", 0, 0, 1, 0, 1);
        id_matr = 1'b0;
    endtask
    initial begin
        #1;
        do_reset();
        run_load(OP_LOAD_A, 3);
        idle(1);
        run_compute(1, -1);
        run_rsvd();
        run_load(OP_LOAD_A, $urandom_range(1, TO));
        run_load(OP_LOAD_B, $urandom_range(1, TO));
        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 3))
                0: run_load(2'($urandom_range(0, 1)), $urandom_range(1, TO));
                1: run_compute($urandom_range(1, TO), -1);
                2: run_rsvd();
                default: idle($urandom_range(1, 3));
            endcase
        end
        run_load(OP_LOAD_B, TO);
        run_timeout(OP_LOAD_A);
        run_compute(2, -1);
        run_rsvd();
        idle(2);
        run_timeout(OP_COMPUTE);
        run_load(OP_LOAD_A, 1);
        run_compute(3, 30);
        run_compute(1, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
